// File: rtl/cmp_stream_unit.sv
// Streaming compare/min/max unit with a one-deep output register and a running
// min/max accumulator that counts the samples it has absorbed.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_EMPTY    | accumulator holds no sample; next ACC op loads a directly
// ST_TRACKING | accumulator holds a value; ACC ops fold a into it
module cmp_stream_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_fun,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_acc,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [3:0] OP_EQ      = 4'b1001;
  localparam logic [3:0] OP_GT      = 4'b1010;
  localparam logic [3:0] OP_LT      = 4'b1011;
  localparam logic [3:0] OP_MIN     = 4'b1100;
  localparam logic [3:0] OP_MAX     = 4'b1101;
  localparam logic [3:0] OP_ACC_MIN = 4'b1110;
  localparam logic [3:0] OP_ACC_MAX = 4'b1111;

  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_TRACKING = 1'b1
  } st_t;

  st_t              state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data;
  logic             res_flag;
  logic             xfer_in;
  logic             is_acc_op;
  logic             load_fresh;

  function automatic logic less_than(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             sgn);
    if (sgn) return $signed(x) < $signed(y);
    return x < y;
  endfunction

  assign in_ready   = !out_valid || out_ready;
  assign xfer_in    = in_valid && in_ready;
  assign is_acc_op  = (alu_fun == OP_ACC_MIN) || (alu_fun == OP_ACC_MAX);
  // A clear on the same transfer makes the ACC op behave as a fresh load.
  assign load_fresh = clr_acc || (state_q == ST_EMPTY);
  assign acc_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (xfer_in) begin
      if (clr_acc) begin
        state_d = ST_EMPTY;
        acc_d   = '0;
        cnt_d   = '0;
      end
      if (is_acc_op) begin
        if (load_fresh) begin
          state_d = ST_TRACKING;
          acc_d   = a;
          cnt_d   = CNT_W'(1);
        end else begin
          if (alu_fun == OP_ACC_MIN)
            acc_d = less_than(a, acc_q, signed_mode) ? a : acc_q;
          else
            acc_d = less_than(acc_q, a, signed_mode) ? a : acc_q;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    res_data = '0;
    res_flag = 1'b0;
    case (alu_fun)
      OP_EQ: begin
        res_data = (a == b) ? WIDTH'(1) : '0;
        res_flag = 1'b1;
      end
      OP_GT: begin
        res_data = less_than(b, a, signed_mode) ? WIDTH'(2) : '0;
        res_flag = 1'b1;
      end
      OP_LT: begin
        res_data = less_than(a, b, signed_mode) ? WIDTH'(3) : '0;
        res_flag = 1'b1;
      end
      OP_MIN: begin
        res_data = less_than(b, a, signed_mode) ? b : a;
        res_flag = 1'b1;
      end
      OP_MAX: begin
        res_data = less_than(a, b, signed_mode) ? b : a;
        res_flag = 1'b1;
      end
      OP_ACC_MIN, OP_ACC_MAX: begin
        res_data = acc_d;
        res_flag = 1'b1;
      end
      default: begin
        res_data = '0;
        res_flag = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flag  <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_flag  <= res_flag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Scoreboard bench for cmp_stream_unit; a second instance with CNT_W=2 shares
// the stimulus so the saturating counter is checked alongside the main one.
module tb_cmp_stream_unit;

  typedef struct packed {
    logic [15:0] data;
    logic        flag;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  alu_fun = '0;
  logic        signed_mode = 1'b0, in_valid = 1'b0, clr_acc = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_flag, out_valid;
  logic [15:0] out_data;
  logic [7:0]  acc_count;
  logic        in_ready2, out_flag2, out_valid2;
  logic [15:0] out_data2;
  logic [1:0]  acc_count2;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   w;

  cmp_stream_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .alu_fun(alu_fun), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .clr_acc(clr_acc), .out_data(out_data),
    .out_flag(out_flag), .out_valid(out_valid), .out_ready(out_ready), .acc_count(acc_count)
  );

  cmp_stream_unit #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .alu_fun(alu_fun), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready2), .clr_acc(clr_acc), .out_data(out_data2),
    .out_flag(out_flag2), .out_valid(out_valid2), .out_ready(out_ready), .acc_count(acc_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tbv, input logic [3:0] f,
                      input logic s, input logic c, input logic [15:0] ed,
                      input logic ef, input logic [7:0] ec, output int waited);
    exp_t e;
    a = ta; b = tbv; alu_fun = f; signed_mode = s; clr_acc = c; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled required=accepted op=%b", f);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.data = ed; e.flag = ef; e.cnt = ec;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    clr_acc  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_flag", 32'(out_flag), 32'(mon_e.flag));
        chk("acc_count", 32'(acc_count), 32'(mon_e.cnt));
        chk("acc_count_sat2", 32'(acc_count2), (mon_e.cnt > 8'd3) ? 32'd3 : 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flag", 32'(out_flag), 32'd0);
    chk("rst_acc_count", 32'(acc_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // compares: unsigned vs signed
    send(16'h8000, 16'h0001, 4'b1010, 1'b0, 1'b0, 16'd2, 1'b1, 8'd0, w);
    send(16'h8000, 16'h0001, 4'b1010, 1'b1, 1'b0, 16'd0, 1'b1, 8'd0, w);
    send(16'd5, 16'd5, 4'b1001, 1'b0, 1'b0, 16'd1, 1'b1, 8'd0, w);
    send(16'd5, 16'd6, 4'b1001, 1'b0, 1'b0, 16'd0, 1'b1, 8'd0, w);
    send(16'd3, 16'd7, 4'b1011, 1'b0, 1'b0, 16'd3, 1'b1, 8'd0, w);
    send(16'hFFFF, 16'd1, 4'b1011, 1'b1, 1'b0, 16'd3, 1'b1, 8'd0, w);
    send(16'hFFFF, 16'd1, 4'b1011, 1'b0, 1'b0, 16'd0, 1'b1, 8'd0, w);
    send(16'hFFFE, 16'd2, 4'b1100, 1'b1, 1'b0, 16'hFFFE, 1'b1, 8'd0, w);
    send(16'hFFFE, 16'd2, 4'b1100, 1'b0, 1'b0, 16'd2, 1'b1, 8'd0, w);
    send(16'hFFFE, 16'd2, 4'b1101, 1'b0, 1'b0, 16'hFFFE, 1'b1, 8'd0, w);
    send(16'hFFFE, 16'd2, 4'b1101, 1'b1, 1'b0, 16'd2, 1'b1, 8'd0, w);
    // unsupported opcodes
    send(16'd5, 16'd5, 4'b0000, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, w);
    send(16'd5, 16'd5, 4'b0111, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, w);

    // accumulator stream, clear-with-load, mixed min/max, saturating twin
    send(16'd5, 16'd0, 4'b1111, 1'b0, 1'b1, 16'd5, 1'b1, 8'd1, w);
    send(16'd9, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd9, 1'b1, 8'd2, w);
    send(16'd3, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd9, 1'b1, 8'd3, w);
    send(16'd7, 16'd0, 4'b1110, 1'b0, 1'b1, 16'd7, 1'b1, 8'd1, w);
    send(16'd10, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd10, 1'b1, 8'd2, w);
    send(16'd1, 16'd1, 4'b1001, 1'b0, 1'b0, 16'd1, 1'b1, 8'd2, w);
    send(16'hFFF0, 16'd0, 4'b1110, 1'b1, 1'b0, 16'hFFF0, 1'b1, 8'd3, w);
    send(16'd20, 16'd0, 4'b1111, 1'b0, 1'b0, 16'hFFF0, 1'b1, 8'd4, w);
    send(16'd1, 16'd0, 4'b1110, 1'b0, 1'b0, 16'd1, 1'b1, 8'd5, w);
    send(16'd2, 16'd2, 4'b1001, 1'b0, 1'b1, 16'd1, 1'b1, 8'd0, w);
    send(16'd8, 16'd0, 4'b1110, 1'b0, 1'b0, 16'd8, 1'b1, 8'd1, w);

    // backpressure: pending result held, stalled ACC op has no effect
    idle_cycle();
    out_ready = 1'b0;
    send(16'd9, 16'd4, 4'b1010, 1'b0, 1'b0, 16'd2, 1'b1, 8'd1, w);
    a = 16'h0064; b = 16'd0; alu_fun = 4'b1111; signed_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_data", 32'(out_data), 32'd2);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_acc_count", 32'(acc_count), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h0064, 16'd0, 4'b1111, 1'b0, 1'b0, 16'h0064, 1'b1, 8'd2, w);
    chk("b2b_wait0", 32'(w), 32'd0);
    send(16'd3, 16'd3, 4'b1001, 1'b0, 1'b0, 16'd1, 1'b1, 8'd2, w);
    chk("b2b_wait1", 32'(w), 32'd0);
    send(16'd4, 16'd9, 4'b1101, 1'b0, 1'b0, 16'd9, 1'b1, 8'd2, w);
    chk("b2b_wait2", 32'(w), 32'd0);

    // async reset mid-stream with a pending result and acc_count=4
    send(16'd1, 16'd0, 4'b1111, 1'b0, 1'b1, 16'd1, 1'b1, 8'd1, w);
    send(16'd2, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd2, 1'b1, 8'd2, w);
    send(16'd3, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd3, 1'b1, 8'd3, w);
    send(16'd4, 16'd0, 4'b1111, 1'b0, 1'b0, 16'd4, 1'b1, 8'd4, w);
    out_ready = 1'b0;
    @(negedge clk); #2;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_acc_count", 32'(acc_count), 32'd4);
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_out_flag", 32'(out_flag), 32'd0);
    chk("async_rst_acc_count", 32'(acc_count), 32'd0);
    chk("async_rst_acc_count_sat2", 32'(acc_count2), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(16'h0050, 16'd0, 4'b1110, 1'b0, 1'b0, 16'h0050, 1'b1, 8'd1, w);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_scoreboard", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
